// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared FSM state encoding and opcode constants for the ALU arbiter.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; on a tie the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid[0] && valid[1]) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one registered external ALU between two requesters,
// one transaction at a time: IDLE -> ISSUE -> CAPTURE -> RESP.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_zero,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              busy
);

  state_t state, next_state;
  logic [1:0] valid_vec, grant, rsp_ready_vec;
  logic       last_grant, grant_idx;
  logic [1:0] rsp_valid_q, rsp_zero_q;
  logic [1:0][DATA_W-1:0] rsp_data_q;

  assign valid_vec     = {req1_valid, req0_valid};
  assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

  rr_arb2 u_rr_arb2 (
    .valid      (valid_vec),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|grant) next_state = ISSUE;
      ISSUE:   next_state = CAPTURE;
      CAPTURE: next_state = RESP;
      RESP:    if (rsp_ready_vec[grant_idx]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant implies valid, so ready in IDLE is exactly the handshake enable.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b1;
    if (state == IDLE) begin
      req0_ready = grant[0];
      req1_ready = grant[1];
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      grant_idx   <= 1'b0;
      last_grant  <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp_zero_q  <= 2'b00;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            grant_idx  <= grant[1];
            alu_opcode <= grant[1] ? req1_opcode : req0_opcode;
            alu_a      <= grant[1] ? req1_a      : req0_a;
            alu_b      <= grant[1] ? req1_b      : req0_b;
          end
        end
        CAPTURE: begin
          rsp_valid_q[grant_idx] <= 1'b1;
          rsp_data_q[grant_idx]  <= alu_out;
          rsp_zero_q[grant_idx]  <= alu_zero;
        end
        RESP: begin
          if (rsp_ready_vec[grant_idx]) begin
            rsp_valid_q[grant_idx] <= 1'b0;
            last_grant             <= grant_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp0_zero  = rsp_zero_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp1_data  = rsp_data_q[1];
  assign rsp1_zero  = rsp_zero_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed bench for alu_arbiter with a registered ALU model
// and a scoreboard of expected responses.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] v  = 2'b00;
  logic [1:0] rr = 2'b11;
  logic [2:0] op [2];
  logic [7:0] a  [2];
  logic [7:0] b  [2];
  logic [1:0] rdy, rsp_v, rsp_z;
  logic [7:0] rsp_d [2];
  logic [2:0] alu_opcode;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_out  = 8'h00;
  logic       alu_zero = 1'b0;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  alu_arbiter #(.DATA_W(8), .OP_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_opcode(op[0]), .req0_a(a[0]), .req0_b(b[0]),
    .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_opcode(op[1]), .req1_a(a[1]), .req1_b(b[1]),
    .rsp0_valid(rsp_v[0]), .rsp0_ready(rr[0]), .rsp0_data(rsp_d[0]), .rsp0_zero(rsp_z[0]),
    .rsp1_valid(rsp_v[1]), .rsp1_ready(rr[1]), .rsp1_data(rsp_d[1]), .rsp1_zero(rsp_z[1]),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  function automatic logic [7:0] alu_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'b000:  return x + y;
      3'b001:  return x - y;
      3'b010:  return x & y;
      3'b011:  return x | y;
      3'b100:  return x ^ y;
      3'b101:  return x << 1;
      3'b110:  return x >> 1;
      default: return 8'h00;
    endcase
  endfunction

  // External registered ALU: result appears one clock after its operands.
  always @(posedge clk) begin
    alu_out  <= alu_f(alu_opcode, alu_a, alu_b);
    alu_zero <= (alu_f(alu_opcode, alu_a, alu_b) == 8'h00);
    cyc      <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         n;
    logic [7:0] d;
    logic       z;
    int         t;
  } exp_t;

  exp_t       sb [$];
  logic [1:0] pv     = 2'b00;
  int         cur_n  = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      pv = 2'b00;
    end else begin
      chk("one_ready", {31'd0, rdy[0] && rdy[1]}, 0);
      for (int n = 0; n < 2; n++) begin
        if (v[n] && rdy[n]) begin
          sb.push_back('{n, alu_f(op[n], a[n], b[n]), alu_f(op[n], a[n], b[n]) == 8'h00, cyc});
          cur_n = n;
        end
      end
      if (busy) chk("other_rsp_quiet", {31'd0, rsp_v[1-cur_n]}, 0);
      for (int n = 0; n < 2; n++) begin
        if (rsp_v[n] && !pv[n]) begin
          chk("rsp_expected", {31'd0, sb.size() != 0}, 1);
          if (sb.size() != 0) begin
            chk("latency", cyc - sb[0].t, 3);
            chk("rsp_owner", n, sb[0].n);
          end
        end
        if (rsp_v[n] && rr[n] && sb.size() != 0) begin
          chk("rsp_data", rsp_d[n], sb[0].d);
          chk("rsp_zero", rsp_z[n], sb[0].z);
          void'(sb.pop_front());
        end
      end
      pv = rsp_v;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic send(input int n, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int waited);
    op[n] = o; a[n] = x; b[n] = y; v[n] = 1'b1;
    waited = 0;
    #1;
    while (!rdy[n] && waited < 20) begin
      tick();
      waited++;
    end
    chk("accept", rdy[n], 1);
    tick();
    v[n] = 1'b0;
  endtask

  task automatic finish_txn();
    int w = 0;
    while (busy && w < 30) begin
      tick();
      w++;
    end
    chk("done_timeout", busy, 0);
  endtask

  initial begin
    int w;
    int exp_n;
    for (int i = 0; i < 2; i++) begin op[i] = 3'd0; a[i] = 8'd0; b[i] = 8'd0; end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_rsp_valid", rsp_v, 0);
    chk("rst_rsp0_data", rsp_d[0], 0);
    chk("rst_rsp_zero", rsp_z, 0);
    chk("rst_alu", {alu_opcode, alu_a, alu_b}, 0);
    rst = 1'b0;
    tick();

    // Single requester: 1 + 2, response three cycles after the handshake.
    send(0, 3'b000, 8'h01, 8'h02, w);
    chk("issue_busy", busy, 1);
    tick();
    tick();
    chk("add_valid", rsp_v[0], 1);
    chk("add_data", rsp_d[0], 8'h03);
    chk("add_zero", rsp_z[0], 0);
    tick();
    chk("add_idle", busy, 0);

    // Tie from reset: req0 first, req1 next.
    do_reset();
    v[1] = 1'b1; op[1] = 3'b001; a[1] = 8'h09; b[1] = 8'h04;
    v[0] = 1'b1; op[0] = 3'b000; a[0] = 8'h05; b[0] = 8'h06;
    #1;
    chk("tie_rdy0", rdy[0], 1);
    chk("tie_rdy1", rdy[1], 0);
    send(0, 3'b000, 8'h05, 8'h06, w);
    chk("tie_wait0", w, 0);
    send(1, 3'b001, 8'h09, 8'h04, w);
    chk("tie_wait1", w, 3);
    finish_txn();

    // Clear opcode gives zero result and zero flag.
    send(1, 3'b111, 8'h5a, 8'h33, w);
    tick();
    tick();
    chk("clr_valid", rsp_v[1], 1);
    chk("clr_data", rsp_d[1], 8'h00);
    chk("clr_zero", rsp_z[1], 1);
    finish_txn();
    chk("alu_hold", {alu_opcode, alu_a, alu_b}, {3'b111, 8'h5a, 8'h33});

    // Back-pressure on rsp0 for five cycles while req1 waits.
    rr[0] = 1'b0;
    v[1] = 1'b1; op[1] = 3'b010; a[1] = 8'hcc; b[1] = 8'haa;
    send(0, 3'b100, 8'hf0, 8'h0f, w);
    chk("bp_wait0", w, 0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_v[0], 1);
      chk("bp_data", rsp_d[0], 8'hff);
      chk("bp_rdy1", rdy[1], 0);
      tick();
    end
    rr[0] = 1'b1;
    send(1, 3'b010, 8'hcc, 8'haa, w);
    chk("bp_wait1", w, 1);
    finish_txn();

    // Reset during CAPTURE discards the transaction.
    send(0, 3'b000, 8'h10, 8'h20, w);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rsp_v, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", rsp_v, 0);
    end
    send(1, 3'b001, 8'h30, 8'h10, w);
    finish_txn();

    // Both requesters continuously valid: strict alternation starting with req0.
    for (int i = 0; i < 2; i++) begin
      op[i] = 3'($urandom_range(0, 7)); a[i] = 8'($urandom_range(0, 255)); b[i] = 8'($urandom_range(0, 255));
    end
    v = 2'b11;
    exp_n = 0;
    #1;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      while (!(rdy[0] || rdy[1]) && w < 20) begin
        tick();
        w++;
      end
      chk("alt_accept", {31'd0, rdy[0] || rdy[1]}, 1);
      chk("alt_order", rdy[1], exp_n);
      begin
        int n = rdy[1] ? 1 : 0;
        tick();
        op[n] = 3'($urandom_range(0, 7)); a[n] = 8'($urandom_range(0, 255)); b[n] = 8'($urandom_range(0, 255));
      end
      exp_n = 1 - exp_n;
    end
    v = 2'b00;
    finish_txn();
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
